multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle RV32-style datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB, drives the datapath strobes, bounds
// memory wait states with a counter and traps on illegal opcodes or on a
// wait that exceeds TIMEOUT cycles. TRAP is left only through rst.
module multicycle_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       alu_src,
    output logic       mem_to_reg,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic [2:0] state,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       op_q, op_d;
    logic             illegal_q, illegal_d;
    logic             wait_expired;

    // A wait state has used its whole budget when the counter sits at TIMEOUT-1.
    assign wait_expired = (cnt_q == CNT_LAST);

    // Next-state, wait counter and opcode capture.
    // The counter is zero whenever a wait state is entered because every
    // transition out of FETCH/MEM (and every other state) drives it to 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        op_d    = op_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    state_d = S_TRAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                op_d = opcode;
                case (opcode)
                    OP_R, OP_I, OP_LOAD, OP_STORE,
                    OP_BR, OP_JAL, OP_JALR: state_d = S_EXEC;
                    default:                state_d = S_TRAP;
                endcase
            end
            S_EXEC: begin
                case (op_q)
                    OP_R, OP_I:             state_d = S_WB;
                    OP_LOAD, OP_STORE:      state_d = S_MEM;
                    OP_BR, OP_JAL, OP_JALR: state_d = S_FETCH;
                    default:                state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = (op_q == OP_LOAD) ? S_WB : S_FETCH;
                end else if (wait_expired) begin
                    state_d = S_TRAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
        illegal_d = (state_d == S_TRAP);
    end

    // State registers with synchronous reset overriding every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

    // Datapath strobes decoded from the current state; forced low while rst is high.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        illegal    = 1'b0;
        state      = 3'd0;
        if (!rst) begin
            state   = state_q;
            illegal = illegal_q;
            case (state_q)
                S_FETCH: begin
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_EXEC: begin
                    case (op_q)
                        OP_R: begin
                            alu_op = 2'b10;
                        end
                        OP_I: begin
                            alu_src = 1'b1;
                            alu_op  = 2'b10;
                        end
                        OP_LOAD, OP_STORE: begin
                            alu_src = 1'b1;
                        end
                        OP_BR: begin
                            alu_op   = 2'b01;
                            pc_src   = 2'b01;
                            pc_write = zero;
                        end
                        OP_JAL: begin
                            pc_src    = 2'b10;
                            pc_write  = 1'b1;
                            reg_write = 1'b1;
                        end
                        OP_JALR: begin
                            alu_src   = 1'b1;
                            pc_src    = 2'b11;
                            pc_write  = 1'b1;
                            reg_write = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_read  = (op_q == OP_LOAD);
                    mem_write = (op_q != OP_LOAD);
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (op_q == OP_LOAD);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// plan-based behavioural model of the instruction sequencing.
module tb_multicycle_ctrl;

    localparam int TIMEOUT = 15;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, ir_write, mem_read, mem_write, reg_write;
    logic       alu_src, mem_to_reg, illegal;
    logic [1:0] alu_op, pc_src;
    logic [2:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .alu_src(alu_src),
        .mem_to_reg(mem_to_reg), .alu_op(alu_op), .pc_src(pc_src),
        .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // m_st is the phase number (0 fetch .. 5 trap); m_plan holds the phases
    // still to visit for the current instruction; m_wait counts ready-low cycles.
    int         m_st = 0;
    int         m_wait = 0;
    logic [6:0] m_op = '0;
    int         m_plan[$];
    bit         m_ok = 0;

    function automatic int next_from_plan();
        if (m_plan.size() == 0) return 0;
        return m_plan.pop_front();
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_st = 0; m_wait = 0; m_op = '0; m_plan.delete(); m_ok = 1;
        end else if (m_ok) begin
            case (m_st)
                0, 3: begin
                    if (mem_ready) begin
                        m_wait = 0;
                        m_st = (m_st == 0) ? 1 : next_from_plan();
                    end else begin
                        m_wait++;
                        if (m_wait == TIMEOUT) m_st = 5;
                    end
                end
                1: begin
                    m_op = opcode;
                    m_plan.delete();
                    case (opcode)
                        OP_R, OP_I:             m_plan = '{2, 4};
                        OP_LOAD:                m_plan = '{2, 3, 4};
                        OP_STORE:               m_plan = '{2, 3};
                        OP_BR, OP_JAL, OP_JALR: m_plan = '{2};
                        default:                m_plan.delete();
                    endcase
                    m_st = (m_plan.size() == 0) ? 5 : next_from_plan();
                end
                2, 4: m_st = next_from_plan();
                default: m_st = 5;
            endcase
        end
    end

    // Expected output vector:
    // {pc_write, ir_write, mem_read, mem_write, reg_write, alu_src, mem_to_reg, alu_op, pc_src, state, illegal}
    function automatic logic [14:0] model_out();
        logic pw, iw, mr, mw, rw, as, m2r, il;
        logic [1:0] ao, ps;
        logic [2:0] st;
        {pw, iw, mr, mw, rw, as, m2r, il} = '0;
        ao = 2'b00; ps = 2'b00; st = 3'd0;
        if (!rst) begin
            st = 3'(m_st);
            if (m_st == 0) begin
                mr = 1; iw = mem_ready; pw = mem_ready;
            end else if (m_st == 2) begin
                if (m_op == OP_R)     ao = 2'b10;
                if (m_op == OP_I)     begin as = 1; ao = 2'b10; end
                if (m_op == OP_LOAD || m_op == OP_STORE) as = 1;
                if (m_op == OP_BR)    begin ao = 2'b01; ps = 2'b01; pw = zero; end
                if (m_op == OP_JAL)   begin ps = 2'b10; pw = 1; rw = 1; end
                if (m_op == OP_JALR)  begin as = 1; ps = 2'b11; pw = 1; rw = 1; end
            end else if (m_st == 3) begin
                mr = (m_op == OP_LOAD); mw = (m_op == OP_STORE);
            end else if (m_st == 4) begin
                rw = 1; m2r = (m_op == OP_LOAD);
            end else if (m_st == 5) begin
                il = 1;
            end
        end
        return {pw, iw, mr, mw, rw, as, m2r, ao, ps, st, il};
    endfunction

    // Compare process: every cycle once the model has seen a reset.
    always @(negedge clk) begin
        logic [14:0] act, exp_v;
        if (m_ok) begin
            act = {pc_write, ir_write, mem_read, mem_write, reg_write, alu_src,
                   mem_to_reg, alu_op, pc_src, state, illegal};
            exp_v = model_out();
            n_cmp++;
            if (act !== exp_v) begin
                n_bad++;
                $display("FAIL model_cmp t=%0t actual=%h required=%h (model phase %0d op %b)",
                         $time, act, exp_v, m_st, m_op);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic cyc(input logic r, input logic [6:0] op, input logic z, input logic rdy);
        @(posedge clk);
        #1;
        rst = r; opcode = op; zero = z; mem_ready = rdy;
        #2;
    endtask

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, req);
        end
    endtask

    task automatic do_reset();
        cyc(1, '0, 0, 0);
        chk("rst_state", int'(state), 0);
        chk("rst_mem_read", int'(mem_read), 0);
    endtask

    int stall;

    initial begin
        // R-type, no waits: 0,1,2,4,0
        do_reset();
        cyc(0, OP_R, 0, 1); chk("r_fetch", int'(state), 0); chk("r_fetch_mr", int'(mem_read), 1);
        chk("r_fetch_rw", int'(reg_write), 0);
        cyc(0, OP_R, 0, 1); chk("r_decode", int'(state), 1);
        cyc(0, OP_R, 0, 1); chk("r_exec", int'(state), 2); chk("r_exec_aluop", int'(alu_op), 2);
        chk("r_exec_rw", int'(reg_write), 0);
        cyc(0, OP_R, 0, 1); chk("r_wb", int'(state), 4); chk("r_wb_rw", int'(reg_write), 1);
        cyc(0, OP_R, 0, 1); chk("r_back", int'(state), 0);

        // Load with three ready-low MEM cycles
        do_reset();
        cyc(0, OP_LOAD, 0, 1); cyc(0, OP_LOAD, 0, 1); cyc(0, OP_LOAD, 0, 1);
        chk("ld_exec", int'(state), 2);
        for (int i = 0; i < 3; i++) begin
            cyc(0, OP_LOAD, 0, 0); chk("ld_mem_wait", int'(state), 3); chk("ld_mem_mr", int'(mem_read), 1);
        end
        cyc(0, OP_LOAD, 0, 1); chk("ld_mem_last", int'(state), 3); chk("ld_mem_mr", int'(mem_read), 1);
        cyc(0, OP_LOAD, 0, 1); chk("ld_wb", int'(state), 4); chk("ld_wb_m2r", int'(mem_to_reg), 1);

        // Branch taken then not taken
        do_reset();
        cyc(0, OP_BR, 1, 1); cyc(0, OP_BR, 1, 1); cyc(0, OP_BR, 1, 1);
        chk("br1_exec", int'(state), 2); chk("br1_pcw", int'(pc_write), 1); chk("br1_pcsrc", int'(pc_src), 1);
        cyc(0, OP_BR, 0, 1); chk("br1_ret", int'(state), 0);
        cyc(0, OP_BR, 0, 1); cyc(0, OP_BR, 0, 1);
        chk("br0_exec", int'(state), 2); chk("br0_pcw", int'(pc_write), 0);
        cyc(0, OP_BR, 0, 1); chk("br0_ret", int'(state), 0);

        // Illegal opcode traps, sticky until reset
        do_reset();
        cyc(0, 7'h7f, 0, 1); cyc(0, 7'h7f, 0, 1); chk("ill_decode", int'(state), 1);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 7'($urandom), 1'($urandom), 1'($urandom));
            chk("ill_state", int'(state), 5); chk("ill_flag", int'(illegal), 1);
        end
        cyc(1, OP_R, 0, 1); chk("ill_rst_state", int'(state), 0); chk("ill_rst_flag", int'(illegal), 0);
        cyc(0, OP_R, 0, 1); chk("ill_after_state", int'(state), 0); chk("ill_after_flag", int'(illegal), 0);
        chk("ill_after_mr", int'(mem_read), 1);

        // Fetch timeout: 15 wait cycles then TRAP
        do_reset();
        for (int i = 0; i < TIMEOUT; i++) begin
            cyc(0, OP_R, 0, 0); chk("to_fetch", int'(state), 0);
        end
        cyc(0, OP_R, 0, 0); chk("to_trap", int'(state), 5);
        // Ready on the 15th cycle completes normally
        do_reset();
        for (int i = 0; i < TIMEOUT - 1; i++) cyc(0, OP_R, 0, 0);
        cyc(0, OP_R, 0, 1); chk("to_last_fetch", int'(state), 0); chk("to_last_irw", int'(ir_write), 1);
        cyc(0, OP_R, 0, 1); chk("to_last_decode", int'(state), 1);

        // Reset during store MEM with ready high
        do_reset();
        cyc(0, OP_STORE, 0, 1); cyc(0, OP_STORE, 0, 1); cyc(0, OP_STORE, 0, 1);
        cyc(0, OP_STORE, 0, 0); chk("st_mem", int'(state), 3); chk("st_mem_mw", int'(mem_write), 1);
        cyc(1, OP_STORE, 0, 1); chk("st_rst_mw", int'(mem_write), 0); chk("st_rst_state", int'(state), 0);
        cyc(0, OP_STORE, 0, 1); chk("st_after", int'(state), 0); chk("st_after_mr", int'(mem_read), 1);

        // Randomized traffic
        stall = 0;
        for (int i = 0; i < 4000; i++) begin
            logic [6:0] op;
            logic rdy;
            int k;
            k = $urandom_range(0, 7);
            case (k)
                0: op = OP_R;  1: op = OP_I;   2: op = OP_LOAD; 3: op = OP_STORE;
                4: op = OP_BR; 5: op = OP_JAL; 6: op = OP_JALR;
                default: op = ($urandom_range(0, 1) == 0) ? 7'($urandom) : OP_LOAD;
            endcase
            if (stall > 0) begin
                rdy = 0; stall--;
            end else if ($urandom_range(0, 19) == 0) begin
                stall = $urandom_range(5, 18); rdy = 0;
            end else begin
                rdy = ($urandom_range(0, 3) != 0);
            end
            cyc(($urandom_range(0, 79) == 0), op, 1'($urandom), rdy);
        end

        @(posedge clk);
        #6;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
